// File: rtl/ppu_vram_arbiter_if.sv
// Purpose : VRAM bus bundle shared by the render fetch path, the CPU $2007
//           port and the multiplexed PPU_AD/ALE/RD/WR memory bus.
// Modports: slave  - the arbiter (consumes requests, drives the memory bus)
//           master - the environment (requesters plus external memory)
// Signals : tick, renderMode, renderReq/Addr/Ack/Data,
//           cpuStrobe/Write/Addr/WData/Busy/Done/RData, paletteHit,
//           adOut, adOE, adIn, ALE, RD, WR
interface ppu_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              tick;
  logic              renderMode;
  logic              renderReq;
  logic [ADDR_W-1:0] renderAddr;
  logic              renderAck;
  logic [7:0]        renderData;
  logic              cpuStrobe;
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [7:0]        cpuWData;
  logic              cpuBusy;
  logic              cpuDone;
  logic [7:0]        cpuRData;
  logic              paletteHit;
  logic [ADDR_W-1:0] adOut;
  logic              adOE;
  logic [7:0]        adIn;
  logic              ALE;
  logic              RD;
  logic              WR;

  modport slave (
    input  tick, renderMode, renderReq, renderAddr,
    input  cpuStrobe, cpuWrite, cpuAddr, cpuWData, adIn,
    output renderAck, renderData, cpuBusy, cpuDone, cpuRData, paletteHit,
    output adOut, adOE, ALE, RD, WR
  );

  modport master (
    output tick, renderMode, renderReq, renderAddr,
    output cpuStrobe, cpuWrite, cpuAddr, cpuWData, adIn,
    input  renderAck, renderData, cpuBusy, cpuDone, cpuRData, paletteHit,
    input  adOut, adOE, ALE, RD, WR
  );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// Purpose : Arbitrates the PPU VRAM bus between render fetches and the CPU
//           $2007 port. Each external access is a two-tick LATCH/STROBE
//           cycle; palette-space CPU accesses complete without bus activity.
// Ports   : CLK - system clock; RST - asynchronous active-high reset;
//           bus - ppu_vram_arbiter_if.slave (requests, responses, PPU_AD bus).
// Option  : define VRAM_ARB_STARVE_GUARD_EN to force a CPU grant after
//           MAX_CPU_WAIT render grants taken while a CPU access waits.
module ppu_vram_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned MAX_CPU_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  ppu_vram_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LATCH  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;

  logic [1:0]        r_state,  w_state_nx;
  logic              r_ale,    w_ale_nx;
  logic              r_rd,     w_rd_nx;
  logic              r_wr,     w_wr_nx;
  logic              r_oe,     w_oe_nx;
  logic [ADDR_W-1:0] r_ad,     w_ad_nx;
  logic              r_rack,   w_rack_nx;
  logic              r_cdone,  w_cdone_nx;
  logic              r_phit,   w_phit_nx;
  logic [DATA_W-1:0] r_rdata,  w_rdata_nx;
  logic [DATA_W-1:0] r_crdata, w_crdata_nx;
  logic              r_pend,   w_pend_nx;   // CPU access waiting for a grant
  logic              r_busy,   w_busy_nx;   // CPU access waiting or in flight
  logic              r_own_cpu, w_own_nx;   // owner of the access on the bus
  logic              r_buf_wr,  w_buf_wr_nx;
  logic [ADDR_W-1:0] r_buf_addr, w_buf_addr_nx;
  logic [DATA_W-1:0] r_buf_wdata, w_buf_wdata_nx;

  logic w_pal, w_cpu_rdy, w_starve, w_gnt_ren, w_gnt_cpu, w_go;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  logic [WAIT_W-1:0] r_wait, w_wait_nx;
  assign w_starve = (r_wait >= WAIT_W'(MAX_CPU_WAIT));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |MAX_CPU_WAIT;
  assign w_starve     = 1'b0;
`endif

  // Palette-space CPU accesses never compete for the bus
  assign w_pal     = (r_buf_addr[13:8] == 6'h3F);
  assign w_cpu_rdy = r_pend & ~w_pal;

  // Grant priority follows renderMode unless the CPU has waited too long
  always_comb begin
    w_gnt_ren = 1'b0;
    w_gnt_cpu = 1'b0;
    if (bus.renderMode && !w_starve) begin
      w_gnt_ren = bus.renderReq;
      w_gnt_cpu = ~bus.renderReq & w_cpu_rdy;
    end else begin
      w_gnt_cpu = w_cpu_rdy;
      w_gnt_ren = bus.renderReq & ~w_cpu_rdy;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nx     = r_state;
    w_ale_nx       = r_ale;
    w_rd_nx        = r_rd;
    w_wr_nx        = r_wr;
    w_oe_nx        = r_oe;
    w_ad_nx        = r_ad;
    w_rack_nx      = 1'b0;
    w_cdone_nx     = 1'b0;
    w_phit_nx      = 1'b0;
    w_rdata_nx     = r_rdata;
    w_crdata_nx    = r_crdata;
    w_pend_nx      = r_pend;
    w_busy_nx      = r_busy;
    w_own_nx       = r_own_cpu;
    w_buf_wr_nx    = r_buf_wr;
    w_buf_addr_nx  = r_buf_addr;
    w_buf_wdata_nx = r_buf_wdata;
    w_go           = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    w_wait_nx      = r_wait;
`endif

    if (bus.tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_pend && w_pal) begin
            w_cdone_nx  = 1'b1;
            w_phit_nx   = 1'b1;
            w_crdata_nx = '0;
            w_pend_nx   = 1'b0;
            w_busy_nx   = 1'b0;
          end
          w_go = w_gnt_ren | w_gnt_cpu;
        end
        S_LATCH: begin
          w_state_nx = S_STROBE;
          w_ale_nx   = 1'b0;
          if (r_own_cpu && r_buf_wr) begin
            w_wr_nx = 1'b0;
            w_ad_nx = {r_ad[ADDR_W-1:DATA_W], r_buf_wdata};
          end else begin
            w_rd_nx = 1'b0;
          end
        end
        S_STROBE: begin
          w_rd_nx    = 1'b1;
          w_wr_nx    = 1'b1;
          w_state_nx = S_IDLE;
          w_oe_nx    = 1'b0;
          if (r_own_cpu) begin
            w_cdone_nx = 1'b1;
            w_busy_nx  = 1'b0;
            if (!r_buf_wr) w_crdata_nx = bus.adIn;
          end else begin
            w_rack_nx  = 1'b1;
            w_rdata_nx = bus.adIn;
          end
          w_go = w_gnt_ren | w_gnt_cpu;
        end
        default: w_state_nx = S_IDLE;
      endcase

      // A grant from IDLE or from the end of STROBE opens a new LATCH
      if (w_go) begin
        w_state_nx = S_LATCH;
        w_ale_nx   = 1'b1;
        w_oe_nx    = 1'b1;
        w_rd_nx    = 1'b1;
        w_wr_nx    = 1'b1;
        w_own_nx   = w_gnt_cpu;
        if (w_gnt_cpu) begin
          w_ad_nx   = r_buf_addr;
          w_pend_nx = 1'b0;
        end else begin
          w_ad_nx   = bus.renderAddr;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        if (w_gnt_cpu)      w_wait_nx = '0;
        else if (w_cpu_rdy) w_wait_nx = r_wait + WAIT_W'(1);
`endif
      end
    end

    // CPU capture is independent of tick; busy already covers completion
    if (bus.cpuStrobe && !r_busy) begin
      w_buf_wr_nx    = bus.cpuWrite;
      w_buf_addr_nx  = bus.cpuAddr;
      w_buf_wdata_nx = bus.cpuWData;
      w_pend_nx      = 1'b1;
      w_busy_nx      = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_ale       <= 1'b0;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_oe        <= 1'b0;
      r_ad        <= '0;
      r_rack      <= 1'b0;
      r_cdone     <= 1'b0;
      r_phit      <= 1'b0;
      r_rdata     <= '0;
      r_crdata    <= '0;
      r_pend      <= 1'b0;
      r_busy      <= 1'b0;
      r_own_cpu   <= 1'b0;
      r_buf_wr    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      r_wait      <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_ale       <= w_ale_nx;
      r_rd        <= w_rd_nx;
      r_wr        <= w_wr_nx;
      r_oe        <= w_oe_nx;
      r_ad        <= w_ad_nx;
      r_rack      <= w_rack_nx;
      r_cdone     <= w_cdone_nx;
      r_phit      <= w_phit_nx;
      r_rdata     <= w_rdata_nx;
      r_crdata    <= w_crdata_nx;
      r_pend      <= w_pend_nx;
      r_busy      <= w_busy_nx;
      r_own_cpu   <= w_own_nx;
      r_buf_wr    <= w_buf_wr_nx;
      r_buf_addr  <= w_buf_addr_nx;
      r_buf_wdata <= w_buf_wdata_nx;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      r_wait      <= w_wait_nx;
`endif
    end
  end

  assign bus.ALE        = r_ale;
  assign bus.RD         = r_rd;
  assign bus.WR         = r_wr;
  assign bus.adOE       = r_oe;
  assign bus.adOut      = r_ad;
  assign bus.renderAck  = r_rack;
  assign bus.renderData = r_rdata;
  assign bus.cpuDone    = r_cdone;
  assign bus.cpuRData   = r_crdata;
  assign bus.paletteHit = r_phit;
  assign bus.cpuBusy    = r_busy;
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Purpose : Self-checking bench for ppu_vram_arbiter. An external VRAM model
//           answers the bus; a byte-level reference memory predicts every
//           read. Honours VRAM_ARB_STARVE_GUARD_EN for the starvation case.
`timescale 1ns/1ps
module tb_ppu_vram_arbiter;
  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned MAX_CPU_WAIT = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ppu_vram_arbiter_if #(.ADDR_W(ADDR_W)) vif ();

  ppu_vram_arbiter #(.ADDR_W(ADDR_W), .MAX_CPU_WAIT(MAX_CPU_WAIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (vif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Default VRAM contents: a fixed scramble of the address
  function automatic logic [7:0] hash8(input logic [ADDR_W-1:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37;
    return t[7:0] ^ t[15:8] ^ 8'h5A;
  endfunction

  // External VRAM: writable window 0x2000-0x2FFF, everything else read-only
  logic [ADDR_W-1:0] bfm_lat;
  logic [7:0]        bfm_mem [0:4095];
  logic              bfm_vld [0:4095];
  logic              ale_q;
  int                n_lat = 0;
  int                pal_bus = 0;
  logic [ADDR_W-1:0] last_lat;
  logic              rd_force_en;
  logic [7:0]        rd_force;

  always @(posedge CLK) begin
    ale_q <= vif.ALE;
    if (vif.ALE) bfm_lat <= vif.adOut;
    if (vif.ALE && !ale_q) begin
      n_lat    <= n_lat + 1;
      last_lat <= vif.adOut;
      if (vif.adOut[13:8] == 6'h3F) pal_bus <= pal_bus + 1;
    end
    if (RST) begin
      for (int i = 0; i < 4096; i++) bfm_vld[i] <= 1'b0;
    end else if (!vif.WR && bfm_lat[13:12] == 2'b10) begin
      bfm_mem[bfm_lat[11:0]] <= vif.adOut[7:0];
      bfm_vld[bfm_lat[11:0]] <= 1'b1;
    end
  end

  always_comb begin
    if (vif.RD)                                              vif.adIn = 8'hEE;
    else if (rd_force_en)                                    vif.adIn = rd_force;
    else if (bfm_lat[13:12] == 2'b10 && bfm_vld[bfm_lat[11:0]]) vif.adIn = bfm_mem[bfm_lat[11:0]];
    else                                                     vif.adIn = hash8(bfm_lat);
  end

  // Reference memory: bytes written by completed CPU writes, else defaults
  logic [7:0] ref_w [int];
  function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_w.exists(32'(a))) return ref_w[32'(a)];
    return hash8(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t);
    vif.tick = t;
    @(posedge CLK);
    #1;
  endtask

  task automatic tk();
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic cpu_go(input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    vif.cpuWrite  = w;
    vif.cpuAddr   = a;
    vif.cpuWData  = d;
    vif.cpuStrobe = 1'b1;
    cyc(1'b0);
    vif.cpuStrobe = 1'b0;
  endtask

  task automatic wait_cpu(input int max_ticks, output logic got, output logic [7:0] rdata,
                          output logic phit);
    got = 1'b0; rdata = '0; phit = 1'b0;
    for (int i = 0; i < max_ticks && !got; i++) begin
      tk();
      if (vif.cpuDone) begin
        got = 1'b1; rdata = vif.cpuRData; phit = vif.paletteHit;
      end
    end
    if (!got) chk("cpu_done_timeout", 32'(got), 32'(1));
  endtask

  logic [7:0]        rd8;
  logic              got, ph;
  int                n0, acks, dones, acks_at_done;
  logic              cpu_open, ren_open, w, pal;
  logic [ADDR_W-1:0] a, raddr;
  logic [7:0]        d, exp_rd;
  int                kind;

  initial begin
    RST = 1'b1;
    vif.tick = 1'b0; vif.renderMode = 1'b0; vif.renderReq = 1'b0; vif.renderAddr = '0;
    vif.cpuStrobe = 1'b0; vif.cpuWrite = 1'b0; vif.cpuAddr = '0; vif.cpuWData = '0;
    rd_force_en = 1'b0; rd_force = 8'h00;
    repeat (3) cyc(1'b0);

    // Reset values
    chk("rst_ctl", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE, vif.cpuBusy,
                        vif.renderAck, vif.cpuDone, vif.paletteHit}), 32'(8'b0110_0000));
    chk("rst_adout", 32'(vif.adOut), 32'(0));
    chk("rst_data", 32'({vif.renderData, vif.cpuRData}), 32'(0));
    RST = 1'b0;
    cyc(1'b0);

    // Reset in the middle of a STROBE read
    cpu_go(1'b0, 14'h0123, 8'h00);
    chk("a_busy", 32'(vif.cpuBusy), 32'(1));
    tk();
    chk("a_latch", 32'({vif.ALE, vif.adOut}), 32'({1'b1, 14'h0123}));
    tk();
    chk("a_strobe_rd", 32'(vif.RD), 32'(0));
    RST = 1'b1;
    #1;
    chk("a_async_ctl", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE, vif.cpuBusy}), 32'(5'b01100));
    chk("a_async_ad", 32'(vif.adOut), 32'(0));
    cyc(1'b0); cyc(1'b0);
    RST = 1'b0;
    n0 = n_lat;
    tk(); tk();
    chk("a_pend_cleared", 32'(n_lat - n0), 32'(0));

    // CPU write 0x55 to 0x2005 with renderMode=0
    cpu_go(1'b1, 14'h2005, 8'h55);
    tk();
    chk("b_latch_ctl", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE}), 32'(4'b1111));
    chk("b_latch_ad", 32'(vif.adOut), 32'(14'h2005));
    chk("b_no_done1", 32'(vif.cpuDone), 32'(0));
    tk();
    chk("b_strobe_ctl", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE}), 32'(4'b0101));
    chk("b_strobe_ad", 32'(vif.adOut), 32'(14'h2055));
    chk("b_no_done2", 32'(vif.cpuDone), 32'(0));
    tk();
    chk("b_done_tick3", 32'({vif.cpuDone, vif.cpuBusy}), 32'(2'b10));
    chk("b_end_ctl", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE}), 32'(4'b0110));
    cyc(1'b0);
    chk("b_done_one_clk", 32'(vif.cpuDone), 32'(0));
    ref_w[32'h2005] = 8'h55;

    // CPU read of 0x0123 with the bus returning 0xA7
    rd_force = 8'hA7; rd_force_en = 1'b1;
    cpu_go(1'b0, 14'h0123, 8'h00);
    tk();
    chk("c_latch_rd", 32'({vif.ALE, vif.RD}), 32'(2'b11));
    tk();
    chk("c_strobe_rd", 32'({vif.ALE, vif.RD, vif.WR}), 32'(3'b001));
    tk();
    chk("c_done", 32'({vif.cpuDone, vif.RD}), 32'(2'b11));
    chk("c_rdata", 32'(vif.cpuRData), 32'(8'hA7));
    rd_force_en = 1'b0;

    // Read back the earlier write through the bus
    cpu_go(1'b0, 14'h2005, 8'h00);
    wait_cpu(8, got, rd8, ph);
    chk("c2_readback", 32'(rd8), 32'(ref_rd(14'h2005)));

    // Palette-space access completes on the first tick without bus activity
    n0 = n_lat;
    cpu_go(1'b0, 14'h3F10, 8'h00);
    tk();
    chk("d_pal_done", 32'({vif.cpuDone, vif.paletteHit, vif.cpuBusy}), 32'(3'b110));
    chk("d_pal_rdata", 32'(vif.cpuRData), 32'(0));
    chk("d_pal_quiet", 32'({vif.ALE, vif.RD, vif.WR, vif.adOE}), 32'(4'b0110));
    cyc(1'b0);
    chk("d_pal_one_clk", 32'(vif.paletteHit), 32'(0));
    chk("d_pal_no_latch", 32'(n_lat - n0), 32'(0));

    // Second strobe while busy is dropped; strobe alongside cpuDone is accepted
    n0 = n_lat; dones = 0;
    cpu_go(1'b1, 14'h2000, 8'h11);
    cpu_go(1'b1, 14'h2400, 8'h22);
    for (int i = 0; i < 8; i++) begin
      tk();
      if (vif.cpuDone) begin
        dones++;
        if (dones == 1) begin
          ref_w[32'h2000] = 8'h11;
          chk("e_busy_falls", 32'(vif.cpuBusy), 32'(0));
          cpu_go(1'b0, 14'h2000, 8'h00);
          chk("e_same_cycle_accept", 32'(vif.cpuBusy), 32'(1));
          wait_cpu(8, got, rd8, ph);
          chk("e_rd_2000", 32'(rd8), 32'(8'h11));
          break;
        end
      end
    end
    chk("e_one_done", 32'(dones), 32'(1));
    chk("e_latches", 32'(n_lat - n0), 32'(2));
    chk("e_last_latch", 32'(last_lat), 32'(14'h2000));
    cpu_go(1'b0, 14'h2400, 8'h00);
    wait_cpu(8, got, rd8, ph);
    chk("e_2400_untouched", 32'(rd8), 32'(ref_rd(14'h2400)));

    // renderMode=1 with renderReq held and a CPU read pending
    vif.renderMode = 1'b1; vif.renderAddr = 14'h0040; vif.renderReq = 1'b1;
    cpu_go(1'b0, 14'h0100, 8'h00);
    acks = 0; dones = 0; acks_at_done = -1; got = 1'b0; rd8 = '0;
    for (int i = 0; i < 24; i++) begin
      tk();
      if (vif.renderAck) begin
        if (acks == 0) chk("f_render_data", 32'(vif.renderData), 32'(ref_rd(14'h0040)));
        acks++;
      end
      if (vif.cpuDone) begin
        dones++; acks_at_done = acks; got = 1'b1; rd8 = vif.cpuRData;
      end
    end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk("f_acks", 32'(acks), 32'(10));
    chk("f_dones", 32'(dones), 32'(1));
    chk("f_acks_before_cpu", 32'(acks_at_done), 32'(MAX_CPU_WAIT));
`else
    chk("f_acks", 32'(acks), 32'(11));
    chk("f_dones", 32'(dones), 32'(0));
`endif
    vif.renderReq = 1'b0;
    if (!got) wait_cpu(12, got, rd8, ph);
    chk("f_cpu_rdata", 32'(rd8), 32'(ref_rd(14'h0100)));
    repeat (3) tk();

    // Randomized mix of CPU and render traffic against the reference memory
    for (int n = 0; n < 60; n++) begin
      vif.renderMode = 1'($urandom_range(0, 1));
      cpu_open = ($urandom_range(0, 3) != 0);
      ren_open = ($urandom_range(0, 2) == 0) || !cpu_open;
      if (ren_open) begin
        raddr = 14'($urandom_range(0, 16'h1FFF));
        vif.renderAddr = raddr;
        vif.renderReq  = 1'b1;
      end
      w = 1'b0; pal = 1'b0; a = '0; d = '0; exp_rd = '0;
      if (cpu_open) begin
        kind = $urandom_range(0, 7);
        d    = 8'($urandom);
        if (kind == 0) begin
          a = 14'h3F00 | 14'($urandom_range(0, 255)); w = 1'($urandom_range(0, 1)); pal = 1'b1;
        end else if (kind <= 3) begin
          a = 14'h2000 | 14'($urandom_range(0, 4095)); w = 1'b1;
        end else begin
          a = 14'($urandom_range(0, 16'h2FFF));
        end
        exp_rd = pal ? 8'h00 : ref_rd(a);
        cpu_go(w, a, d);
      end
      for (int i = 0; i < 40 && (cpu_open || ren_open); i++) begin
        tk();
        if (ren_open && vif.renderAck) begin
          chk("g_render_data", 32'(vif.renderData), 32'(ref_rd(raddr)));
          vif.renderReq = 1'b0;
          ren_open = 1'b0;
        end
        if (cpu_open && vif.cpuDone) begin
          chk("g_cpu_palhit", 32'(vif.paletteHit), 32'(pal));
          if (!w) chk("g_cpu_rdata", 32'(vif.cpuRData), 32'(exp_rd));
          cpu_open = 1'b0;
        end
      end
      if (cpu_open || ren_open) chk("g_timeout", 32'({cpu_open, ren_open}), 32'(0));
      vif.renderReq = 1'b0;
      if (w && !pal) ref_w[32'(a)] = d;
      repeat (3) tk();
    end
    chk("g_palette_never_on_bus", 32'(pal_bus), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Owns the multiplexed PPU_AD / ALE / RD / WR memory bus.
- Shares the bus between two requesters: the render fetch path (pattern, nametable and attribute fetches) and the CPU $2007 data port.
- Sequences every external access as a two-tick LATCH/STROBE cycle.
- Palette-space CPU accesses are short-circuited so the palette RAM handles them.

Parameters:
- ADDR_W, 14, VRAM address width.
- MAX_CPU_WAIT, 8, render grants allowed while a CPU access is pending; used only with the starvation guard.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- tick  in  1  PPU-rate clock enable; the FSM advances only on CLK edges where tick=1.
- renderMode  in  1  high while rendering is enabled on visible/pre-render lines.
- renderReq  in  1  render fetch request, level; held until renderAck.
- renderAddr  in  ADDR_W  render fetch address; stable while renderReq=1.
- renderAck  out  1  one-CLK pulse; renderData is valid.
- renderData  out  8  captured read byte.
- cpuStrobe  in  1  one-CLK pulse requesting a CPU access.
- cpuWrite  in  1  1=write, 0=read; sampled with cpuStrobe.
- cpuAddr  in  ADDR_W  sampled with cpuStrobe.
- cpuWData  in  8  sampled with cpuStrobe.
- cpuBusy  out  1  high while a CPU access is pending or in flight.
- cpuDone  out  1  one-CLK pulse on CPU access completion.
- cpuRData  out  8  CPU read byte, valid at cpuDone.
- paletteHit  out  1  one-CLK pulse with cpuDone when the access was palette space.
- adOut  out  ADDR_W  bus address/data drive value.
- adOE  out  1  bus output enable; when 0, the top level tristates PPU_AD.
- adIn  in  8  PPU_AD[7:0] read back.
- ALE  out  1  address latch enable, active high.
- RD  out  1  read strobe, active low.
- WR  out  1  write strobe, active low.

Behaviour:
- Reset (async, RST=1) forces the following immediately, including mid-access:
  - state=IDLE, ALE=0, RD=1, WR=1, adOE=0, adOut=0.
  - renderAck=0, cpuDone=0, paletteHit=0, cpuBusy=0.
  - renderData=0, cpuRData=0, CPU pending buffer cleared.
- CPU capture:
  - cpuStrobe loads the pending buffer {write, addr, wdata} and sets pending. This happens on any CLK edge, independent of tick.
  - A cpuStrobe arriving while cpuBusy=1 is dropped; the buffer is unchanged.
- Palette bypass:
  - A pending CPU access with addr[13:8]=6'h3F is never put on the bus.
  - On the next tick with state IDLE it completes: cpuDone=1, paletteHit=1, cpuRData=0.
- Grant rule, evaluated on a tick in IDLE or at the end of STROBE:
  - renderMode=1: renderReq wins over CPU pending; the CPU is granted only when renderReq=0.
  - renderMode=0: CPU pending wins; renderReq is still served when no CPU access is pending.
- FSM (transitions on tick only):
  - IDLE: on grant, latch the address, go to LATCH; otherwise stay.
  - LATCH (1 tick): ALE=1, adOE=1, adOut=granted addr, RD=1, WR=1. Next: STROBE.
  - STROBE (1 tick): ALE=0.
    - Read: RD=0, adOE=1 with adOut[13:8]=addr[13:8] and the low byte released (adOE covers only the upper bits at the top level via the low-byte tristate rule below).
    - Write: WR=0, adOE=1, adOut[7:0]=wdata.
- Low-byte rule: during a STROBE read, the top level tristates PPU_AD[7:0] whenever RD=0.
- End of STROBE (the tick that leaves STROBE):
  - Read: adIn is sampled into renderData or cpuRData.
  - Pulse the requester's ack/done for exactly one CLK. RD and WR return to 1.
  - A CPU completion clears pending, so cpuBusy falls in the same cycle as cpuDone.
  - If a new grant exists, go directly to LATCH (back-to-back); otherwise go to IDLE with adOE=0.
- Timing:
  - Latency from request to ack is 3 ticks.
  - Sustained throughput is one access per 2 ticks.
- Simultaneous events:
  - cpuStrobe in the same cycle as a CPU cpuDone is accepted, because the busy flag falls first.
  - Changing renderMode mid-access does not abort the access; it affects only the next grant.
- Address arithmetic: no wrap is applied; addresses are used as given, ADDR_W bits.

Optional Feature:
- Macro: VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter increments on each render grant while a CPU access is pending.
  - When the counter reaches MAX_CPU_WAIT, the next grant goes to the CPU even if renderReq=1; renderReq is then held, not acked.
  - The counter clears on a CPU grant or on reset.
- Undefined: there is no counter, and the CPU can wait indefinitely while renderMode=1 and renderReq is held.

Test Plan:
- Reset mid-STROBE read (RD=0) → RD=1, ALE=0, adOE=0 in the same cycle that RST rises; cpuBusy=0.
- renderMode=0, CPU write 0x55 to 0x2005 → LATCH: ALE=1, adOut=0x2005; STROBE: WR=0, adOut[7:0]=0x55; cpuDone on the 3rd tick.
- CPU read of 0x0123, adIn=0xA7 during STROBE → cpuRData=0xA7 with cpuDone; RD is low for exactly one tick.
- renderMode=1, renderReq held plus CPU pending →
  - Without the macro: only renderAck pulses, one every 2 ticks.
  - With the macro and MAX_CPU_WAIT=8: after 8 renderAcks, one CPU access, then render resumes.
- CPU access to 0x3F10 → no ALE/RD/WR activity; cpuDone and paletteHit pulse on the first tick.
- Second cpuStrobe while cpuBusy=1 (addr 0x2400 after 0x2000) → only 0x2000 appears on the bus; one cpuDone.
